// File: rtl/dac_frame_rx_if.sv
// rtl/dac_frame_rx_if.sv - serial frame pins and receive-side result bus (optional counters: DACRX_FRAME_CNT_EN)
interface dac_frame_rx_if #(
  parameter int DATA_W = 16
);
  logic              CS;
  logic              CLK;
  logic              SDI;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frame_err;
  logic              busy;
`ifdef DACRX_FRAME_CNT_EN
  logic [15:0]       good_cnt;
  logic [15:0]       err_cnt;

  modport master (output CS, CLK, SDI,
                  input  data, valid, frame_err, busy, good_cnt, err_cnt);
  modport slave  (input  CS, CLK, SDI,
                  output data, valid, frame_err, busy, good_cnt, err_cnt);
`else
  modport master (output CS, CLK, SDI,
                  input  data, valid, frame_err, busy);
  modport slave  (input  CS, CLK, SDI,
                  output data, valid, frame_err, busy);
`endif
endinterface

// File: rtl/dac_frame_rx.sv
// rtl/dac_frame_rx.sv - oversampled 3-wire DAC frame receiver (optional counters: DACRX_FRAME_CNT_EN)
module dac_frame_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           nrst,
  dac_frame_rx_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {ARM, IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_cs_d;
  logic                   r_clk_d;
  state_t                 r_state;
  logic [DATA_W-1:0]      r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_data;
  logic                   r_valid;
  logic                   r_err;
  logic                   r_busy;

  logic w_cs;
  logic w_clk;
  logic w_sdi;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_clk_rise;

  // Synchronize the async pins; CS resets low so a frame already open at reset release is never seen as a fall
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cs_sync  <= '0;
      r_clk_sync <= '1;
      r_sdi_sync <= '0;
      r_cs_d     <= 1'b0;
      r_clk_d    <= 1'b1;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.CS};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.CLK};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], bus.SDI};
      r_cs_d     <= w_cs;
      r_clk_d    <= w_clk;
    end
  end

  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_clk      = r_clk_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_rise  =  w_cs & ~r_cs_d;
  assign w_cs_fall  = ~w_cs &  r_cs_d;
  assign w_clk_rise =  w_clk & ~r_clk_d;

  // Frame FSM: arm on CS high, shift on CLK rises inside the CS-low window, judge bit count on CS rise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ARM;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ARM: begin
          if (w_cs) r_state <= IDLE;
        end
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          // A CS rise wins over a coincident CLK rise, so that edge is never counted
          if (w_cs_rise) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end else if (w_clk_rise && !w_cs) begin
            r_shreg <= {r_shreg[DATA_W-2:0], w_sdi};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (r_bit_cnt == CNT_FULL) begin
            r_data  <= r_shreg;
            r_valid <= 1'b1;
          end else begin
            r_err   <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= ARM;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_err;
  assign bus.busy      = r_busy;

`ifdef DACRX_FRAME_CNT_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_err_cnt;

  // Saturating good/bad frame counters, stepped by the result pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_valid && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_err   && (r_err_cnt  != 16'hFFFF)) r_err_cnt  <= r_err_cnt  + 16'd1;
    end
  end

  assign bus.good_cnt = r_good_cnt;
  assign bus.err_cnt  = r_err_cnt;
`endif

endmodule
